alu_div_sequencer: RTL and testbench



---
 rtl/alu_div_sequencer_if.sv | 30 +++
 rtl/alu_div_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_div_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_div_sequencer_if.sv
// Request/response handshake plus shared-ALU ownership signals for the divide sequencer.
// The slave modport is the sequencer; the master modport is the EX-stage pipeline and ALU.
interface alu_div_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_dividend;
    logic [XLEN-1:0] in_divisor;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] alu_left;
    logic [XLEN-1:0] alu_right;
    logic [XLEN-1:0] alu_result;

    modport slave (
        input  in_valid, in_op, in_dividend, in_divisor, flush, out_ready, alu_result,
        output in_ready, out_valid, out_result, busy, alu_control, alu_left, alu_right
    );

    modport master (
        output in_valid, in_op, in_dividend, in_divisor, flush, out_ready, alu_result,
        input  in_ready, out_valid, out_result, busy, alu_control, alu_left, alu_right
    );
endinterface

// File: rtl/alu_div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: drives the shared ALU through 32 restoring
// subtract steps, handling divide-by-zero and signed overflow without iterating.
module alu_div_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_div_sequencer_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_e;

    state_e          r_state,     w_state;
    logic [1:0]      r_op,        w_op;
    logic [XLEN-1:0] r_dvd,       w_dvd;
    logic [XLEN-1:0] r_dvs,       w_dvs;
    logic [XLEN-1:0] r_rem,       w_rem;
    logic [CNT_W-1:0] r_cnt,      w_cnt;
    logic            r_dvd_neg,   w_dvd_neg;
    logic            r_dvs_neg,   w_dvs_neg;
    logic [XLEN-1:0] r_result,    w_result;
    logic            r_out_valid, w_out_valid;

    logic [3:0]      w_alu_control;
    logic [XLEN-1:0] w_alu_left;
    logic [XLEN-1:0] w_alu_right;
    logic [XLEN:0]   w_rem_s;
    logic            w_ge;
    logic            w_in_signed;

    // One restoring step: shift in the next dividend bit and compare in 33 bits.
    assign w_rem_s     = {r_rem, r_dvd[XLEN-1]};
    assign w_ge        = (w_rem_s >= {1'b0, r_dvs});
    assign w_in_signed = ~bus.in_op[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_op        <= 2'b00;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_dvd_neg   <= 1'b0;
            r_dvs_neg   <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_dvd       <= w_dvd;
            r_dvs       <= w_dvs;
            r_rem       <= w_rem;
            r_cnt       <= w_cnt;
            r_dvd_neg   <= w_dvd_neg;
            r_dvs_neg   <= w_dvs_neg;
            r_result    <= w_result;
            r_out_valid <= w_out_valid;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_op          = r_op;
        w_dvd         = r_dvd;
        w_dvs         = r_dvs;
        w_rem         = r_rem;
        w_cnt         = r_cnt;
        w_dvd_neg     = r_dvd_neg;
        w_dvs_neg     = r_dvs_neg;
        w_result      = r_result;
        w_out_valid   = r_out_valid;
        w_alu_control = ALU_ADD;
        w_alu_left    = '0;
        w_alu_right   = '0;

        if (r_state == ITER) begin
            w_alu_control = ALU_SUB;
            w_alu_left    = w_rem_s[XLEN-1:0];
            w_alu_right   = r_dvs;
        end

        if (bus.flush) begin
            w_state     = IDLE;
            w_out_valid = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w_op      = bus.in_op;
                        w_dvd     = bus.in_dividend;
                        w_dvs     = bus.in_divisor;
                        w_dvd_neg = w_in_signed & bus.in_dividend[XLEN-1];
                        w_dvs_neg = w_in_signed & bus.in_divisor[XLEN-1];
                        if (bus.in_divisor == '0) begin
                            w_result = bus.in_op[1] ? bus.in_dividend : '1;
                            w_state  = DONE;
                        end else if (w_in_signed
                                     && bus.in_dividend == {1'b1, {(XLEN-1){1'b0}}}
                                     && bus.in_divisor == '1) begin
                            w_result = bus.in_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                            w_state  = DONE;
                        end else begin
                            w_state = SETUP;
                        end
                    end
                end
                SETUP: begin
                    w_dvd   = r_dvd_neg ? (XLEN'(0) - r_dvd) : r_dvd;
                    w_dvs   = r_dvs_neg ? (XLEN'(0) - r_dvs) : r_dvs;
                    w_rem   = '0;
                    w_cnt   = '0;
                    w_state = ITER;
                end
                ITER: begin
                    w_rem = w_ge ? bus.alu_result : w_rem_s[XLEN-1:0];
                    w_dvd = {r_dvd[XLEN-2:0], w_ge};
                    w_cnt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        w_state = FIXUP;
                    end
                end
                FIXUP: begin
                    if (r_op[1]) begin
                        w_result = (!r_op[0] && r_dvd_neg) ? (XLEN'(0) - r_rem) : r_rem;
                    end else begin
                        w_result = (!r_op[0] && (r_dvd_neg ^ r_dvs_neg)) ?
                                   (XLEN'(0) - r_dvd) : r_dvd;
                    end
                    w_state = DONE;
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE; consumer handshake returns to IDLE.
                    if (r_out_valid && bus.out_ready) begin
                        w_state     = IDLE;
                        w_out_valid = 1'b0;
                    end else begin
                        w_out_valid = 1'b1;
                    end
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_result;
    assign bus.alu_control = w_alu_control;
    assign bus.alu_left    = w_alu_left;
    assign bus.alu_right   = w_alu_right;
endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer with a behavioural ALU and hand-computed results.
module tb_alu_div_sequencer;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    alu_div_sequencer_if u_if ();

    alu_div_sequencer u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    assign u_if.alu_result = (u_if.alu_control == ALU_SUB) ? (u_if.alu_left - u_if.alu_right)
                                                           : (u_if.alu_left + u_if.alu_right);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with out_ready high; check result, latency, SUB cycles and busy cycles.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_sub, input int exp_busy);
        int cycles;
        int lat;
        int sub_cnt;
        int busy_cnt;
        check({tag, "/in_ready"}, 32'(u_if.in_ready), 32'd1);
        u_if.in_valid    = 1'b1;
        u_if.in_op       = op;
        u_if.in_dividend = a;
        u_if.in_divisor  = b;
        u_if.out_ready   = 1'b1;
        step();
        u_if.in_valid    = 1'b0;
        u_if.in_dividend = 32'hDEAD_BEEF;
        u_if.in_divisor  = 32'h0000_0001;
        cycles   = 0;
        lat      = -1;
        sub_cnt  = 0;
        busy_cnt = 0;
        while (cycles < 100) begin
            if (u_if.busy) busy_cnt++;
            if (u_if.alu_control == ALU_SUB) sub_cnt++;
            if (u_if.out_valid && lat < 0) begin
                lat = cycles;
                check({tag, "/result"}, u_if.out_result, exp_res);
            end
            if (!u_if.busy) break;
            step();
            cycles++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/sub_cycles"}, 32'(sub_cnt), 32'(exp_sub));
        check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "/valid_drop"}, 32'(u_if.out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        n_checks = 0;
        n_errors = 0;
        reset_n          = 1'b0;
        u_if.in_valid    = 1'b0;
        u_if.in_op       = 2'b00;
        u_if.in_dividend = '0;
        u_if.in_divisor  = '0;
        u_if.flush       = 1'b0;
        u_if.out_ready   = 1'b1;
        #22;
        check("rst/out_valid", 32'(u_if.out_valid), 32'd0);
        check("rst/out_result", u_if.out_result, 32'd0);
        check("rst/in_ready", 32'(u_if.in_ready), 32'd1);
        check("rst/busy", 32'(u_if.busy), 32'd0);
        check("rst/alu_control", 32'(u_if.alu_control), 32'(ALU_ADD));
        reset_n = 1'b1;
        step();

        run_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         35, 32, 36);
        run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35, 32, 36);
        run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35, 32, 36);
        run_op("remu_ff_16",   OP_REMU, 32'hFFFF_FFFF,  32'd16,         32'd15,         35, 32, 36);
        run_op("div_100_m7",   OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  35, 32, 36);
        run_op("rem_100_m7",   OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          35, 32, 36);
        run_op("divu_3_7",     OP_DIVU, 32'd3,          32'd7,          32'd0,          35, 32, 36);
        run_op("div_5_0",      OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0,  2);
        run_op("rem_5_0",      OP_REM,  32'd5,          32'd0,          32'd5,          1,  0,  2);
        run_op("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0,  2);
        run_op("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0,  2);

        // Backpressure: result must hold while out_ready is low.
        u_if.in_valid    = 1'b1;
        u_if.in_op       = OP_DIVU;
        u_if.in_dividend = 32'd20;
        u_if.in_divisor  = 32'd6;
        u_if.out_ready   = 1'b0;
        step();
        u_if.in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (u_if.out_valid) begin
                seen = 1;
                break;
            end
            step();
        end
        check("bp/valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp/hold_valid", 32'(u_if.out_valid), 32'd1);
            check("bp/hold_result", u_if.out_result, 32'd3);
            check("bp/hold_in_ready", 32'(u_if.in_ready), 32'd0);
        end
        u_if.out_ready = 1'b1;
        step();
        check("bp/release_in_ready", 32'(u_if.in_ready), 32'd1);
        check("bp/release_valid", 32'(u_if.out_valid), 32'd0);

        // Flush at ITER step 10, then a normal operation.
        u_if.in_valid    = 1'b1;
        u_if.in_op       = OP_DIVU;
        u_if.in_dividend = 32'd1000;
        u_if.in_divisor  = 32'd3;
        step();
        u_if.in_valid = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("flush/in_iter", 32'(u_if.alu_control), 32'(ALU_SUB));
        u_if.flush = 1'b1;
        step();
        u_if.flush = 1'b0;
        check("flush/busy", 32'(u_if.busy), 32'd0);
        check("flush/in_ready", 32'(u_if.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (u_if.out_valid) seen++;
            step();
        end
        check("flush/no_valid", 32'(seen), 32'd0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 35, 32, 36);

        // Asynchronous reset mid-ITER.
        u_if.in_valid    = 1'b1;
        u_if.in_op       = OP_DIV;
        u_if.in_dividend = 32'd77;
        u_if.in_divisor  = 32'd5;
        step();
        u_if.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("arst/pre_busy", 32'(u_if.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst/out_valid", 32'(u_if.out_valid), 32'd0);
        check("arst/busy", 32'(u_if.busy), 32'd0);
        check("arst/in_ready", 32'(u_if.in_ready), 32'd1);
        check("arst/out_result", u_if.out_result, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        run_op("post_rst_div", OP_DIV, 32'd77, 32'd5, 32'd15, 35, 32, 36);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
